// File: rtl/one_hot_to_bin.sv
// one_hot_to_bin: registered one-hot to binary encoder with skid-buffered valid/ready stream
module one_hot_to_bin #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_W-1:0]     err_cnt_o
);
  logic [BIN_W-1:0] enc_bin;
  logic             enc_err;
  logic [BIN_W-1:0] skid_bin;
  logic             skid_err;
  logic             skid_valid;
  logic             acc;
  logic             take;
  // lowest set bit wins; error when zero-hot or more than one bit set
  always_comb begin
    enc_bin = '0;
    for (int i = ONE_HOT_W - 1; i >= 0; i--) if (one_hot_i[i]) enc_bin = BIN_W'(i);
    enc_err = ~|one_hot_i || |(one_hot_i & (one_hot_i - ONE_HOT_W'(1)));
  end
  assign acc  = valid_i && ready_o;
  assign take = !valid_o || ready_i;
  // main refills from skid first to keep FIFO order; ready_o mirrors the next skid state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o    <= 1'b0;
      bin_o      <= '0;
      err_o      <= 1'b0;
      skid_valid <= 1'b0;
      skid_bin   <= '0;
      skid_err   <= 1'b0;
      ready_o    <= 1'b1;
      err_cnt_o  <= '0;
    end else begin
      if (take) begin
        valid_o    <= skid_valid || acc;
        bin_o      <= skid_valid ? skid_bin : enc_bin;
        err_o      <= skid_valid ? skid_err : enc_err;
        skid_valid <= 1'b0;
        ready_o    <= 1'b1;
      end else if (acc) begin
        skid_bin   <= enc_bin;
        skid_err   <= enc_err;
        skid_valid <= 1'b1;
        ready_o    <= 1'b0;
      end
      if (acc && enc_err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_one_hot_to_bin.sv
// tb_one_hot_to_bin: randomized and directed checks against a transaction-level model
module tb_one_hot_to_bin;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vi = 1'b0;
  logic        ri = 1'b0;
  logic [15:0] oh = '0;
  logic        ready_o, err_o, valid_o;
  logic [3:0]  bin_o;
  logic [7:0]  err_cnt_o;
  logic        s_ready, s_err, s_valid;
  logic [3:0]  s_bin;
  logic [1:0]  s_cnt;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [5:0]  model_q[$];
  logic [5:0]  got_q[$];
  logic [5:0]  exp_q[$];
  int          mcnt = 0;
  int          scnt = 0;
  logic [4:0]  e;

  one_hot_to_bin dut (
    .clk(clk), .reset_n(rst_n), .one_hot_i(oh), .valid_i(vi), .ready_o(ready_o),
    .bin_o(bin_o), .err_o(err_o), .valid_o(valid_o), .ready_i(ri), .err_cnt_o(err_cnt_o)
  );

  one_hot_to_bin #(.BIN_W(4), .ONE_HOT_W(16), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(rst_n), .one_hot_i(oh), .valid_i(vi), .ready_o(s_ready),
    .bin_o(s_bin), .err_o(s_err), .valid_o(s_valid), .ready_i(ri), .err_cnt_o(s_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] enc(input logic [15:0] x);
    int idx = 0;
    for (int i = 15; i >= 0; i--) if (x[i]) idx = i;
    return {$countones(x) != 1, 4'(idx)};
  endfunction

  // transaction model: words enter at acceptance, leave in order at consumption
  always @(negedge clk) begin
    if (!rst_n) begin
      model_q.delete();
      mcnt = 0;
      scnt = 0;
    end else begin
      if (valid_o && ri) begin
        got_q.push_back({1'b0, err_o, bin_o});
        if (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
        else exp_q.push_back(6'h3F);
      end
      if (vi && ready_o) begin
        e = enc(oh);
        model_q.push_back({1'b0, e});
        if (e[4]) begin
          mcnt = (mcnt < 255) ? mcnt + 1 : 255;
          scnt = (scnt < 3) ? scnt + 1 : 3;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if ({valid_o, bin_o, err_o} !== 6'b0) begin n_fail++; $display("FAIL reset_out got v=%b b=%0d e=%b want 0", valid_o, bin_o, err_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    n_cmp++; if (err_cnt_o !== 8'd0 || s_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0", err_cnt_o, s_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    got_q.delete(); exp_q.delete();
    oh = 16'h0200; vi = 1'b1; ri = 1'b1;
    step();
    vi = 1'b0;
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", valid_o); end
    n_cmp++; if (bin_o !== 4'd9) begin n_fail++; $display("FAIL single_bin got %0d want 9", bin_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL single_err got %b want 0", err_o); end
    n_cmp++; if (err_cnt_o !== 8'd0) begin n_fail++; $display("FAIL single_cnt got %0d want 0", err_cnt_o); end
    step();
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", valid_o); end
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 6'h09) begin n_fail++; $display("FAIL single_seen got n=%0d want one word 9", got_q.size()); end
  endtask

  task automatic test_stream();
    got_q.delete(); exp_q.delete();
    ri = 1'b1;
    for (int k = 0; k < 16; k++) begin
      oh = 16'h1 << k; vi = 1'b1;
      step();
      n_cmp++;
      if (valid_o !== 1'b1 || bin_o !== 4'(k) || err_o !== 1'b0 || ready_o !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d got v=%b b=%0d e=%b r=%b want 1/%0d/0/1", k, valid_o, bin_o, err_o, ready_o, k);
      end
    end
    vi = 1'b0;
    step();
    n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", got_q.size()); end
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== {2'b0, 4'(k)}) begin n_fail++; $display("FAIL stream_order_%0d got %0h want %0h", k, got_q[k], k); end
    end
  endtask

  task automatic test_malformed();
    ri = 1'b1; oh = 16'h0000; vi = 1'b1;
    step();
    n_cmp++; if ({valid_o, bin_o, err_o} !== {1'b1, 4'd0, 1'b1}) begin n_fail++; $display("FAIL zero_hot got v=%b b=%0d e=%b want 1/0/1", valid_o, bin_o, err_o); end
    oh = 16'h0500;
    step();
    vi = 1'b0;
    n_cmp++; if ({valid_o, bin_o, err_o} !== {1'b1, 4'd8, 1'b1}) begin n_fail++; $display("FAIL multi_hot got v=%b b=%0d e=%b want 1/8/1", valid_o, bin_o, err_o); end
    n_cmp++; if (err_cnt_o !== 8'd2) begin n_fail++; $display("FAIL malformed_cnt got %0d want 2", err_cnt_o); end
    step();
  endtask

  task automatic test_backpressure();
    logic [15:0] w[5] = '{16'h0004, 16'h0010, 16'h8000, 16'h0003, 16'h0000};
    int acc_n = 0;
    logic r;
    got_q.delete(); exp_q.delete();
    ri = 1'b0;
    for (int c = 0; c < 5; c++) begin
      oh = w[acc_n]; vi = 1'b1; r = ready_o;
      step();
      if (r) acc_n++;
    end
    n_cmp++; if (acc_n != 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", acc_n); end
    n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got %b want 0", ready_o); end
    n_cmp++; if (valid_o !== 1'b1 || bin_o !== 4'd2) begin n_fail++; $display("FAIL bp_hold got v=%b b=%0d want 1/2", valid_o, bin_o); end
    ri = 1'b1;
    for (int c = 0; c < 20 && acc_n < 5; c++) begin
      oh = w[acc_n]; vi = 1'b1; r = ready_o;
      step();
      if (r) acc_n++;
      if (c == 0) begin
        n_cmp++; if (ready_o !== 1'b1 || bin_o !== 4'd4) begin n_fail++; $display("FAIL bp_release got r=%b b=%0d want 1/4", ready_o, bin_o); end
      end
    end
    vi = 1'b0;
    step(); step(); step();
    n_cmp++; if (got_q.size() != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== {1'b0, enc(w[i])}) begin n_fail++; $display("FAIL bp_order_%0d got %0h want %0h", i, got_q[i], enc(w[i])); end
    end
    n_cmp++; if (err_cnt_o !== 8'(mcnt)) begin n_fail++; $display("FAIL bp_cnt got %0d want %0d", err_cnt_o, mcnt); end
  endtask

  task automatic test_random();
    int sent = 0;
    logic r, hold, pe;
    logic [3:0] pb;
    got_q.delete(); exp_q.delete();
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      case ($urandom % 4)
        0: oh = 16'h1 << ($urandom % 16);
        1: oh = 16'h0;
        2: oh = 16'($urandom);
        default: oh = (16'h1 << ($urandom % 16)) | (16'h1 << ($urandom % 16));
      endcase
      vi = ($urandom % 4) != 0;
      ri = ($urandom % 3) != 0;
      hold = valid_o && !ri; pb = bin_o; pe = err_o; r = ready_o;
      step();
      if (vi && r) sent++;
      if (hold) begin
        n_cmp++; if (valid_o !== 1'b1 || bin_o !== pb || err_o !== pe) begin n_fail++; $display("FAIL rnd_stable got v=%b b=%0d e=%b want 1/%0d/%b", valid_o, bin_o, err_o, pb, pe); end
      end
    end
    vi = 1'b0; ri = 1'b1;
    step(); step(); step();
    n_cmp++; if (sent != 10000) begin n_fail++; $display("FAIL rnd_budget got %0d want 10000", sent); end
    n_cmp++; if (got_q.size() != sent) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), sent); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_word_%0d got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (err_cnt_o !== 8'(mcnt)) begin n_fail++; $display("FAIL rnd_cnt got %0d want %0d", err_cnt_o, mcnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] sat_exp[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    oh = 16'h0; vi = 1'b1; ri = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++; if (s_cnt !== sat_exp[k] || s_cnt !== 2'(scnt)) begin n_fail++; $display("FAIL sat_%0d got %0d want %0d", k, s_cnt, sat_exp[k]); end
      n_cmp++; if (err_cnt_o !== 8'(k + 1)) begin n_fail++; $display("FAIL sat_wide_%0d got %0d want %0d", k, err_cnt_o, k + 1); end
    end
    vi = 1'b0;
    step();
  endtask

  task automatic test_midreset();
    ri = 1'b0; oh = 16'h0000; vi = 1'b1;
    step();
    oh = 16'h0030;
    step();
    vi = 1'b0;
    n_cmp++; if (ready_o !== 1'b0 || valid_o !== 1'b1 || err_cnt_o === 8'd0) begin n_fail++; $display("FAIL mid_full got r=%b v=%b c=%0d want 0/1/nonzero", ready_o, valid_o, err_cnt_o); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_async got v=%b r=%b want 0/1", valid_o, ready_o); end
    n_cmp++; if (err_cnt_o !== 8'd0 || s_cnt !== 2'd0 || bin_o !== 4'd0 || err_o !== 1'b0) begin n_fail++; $display("FAIL mid_clear got c=%0d b=%0d e=%b want 0", err_cnt_o, bin_o, err_o); end
    step();
    rst_n = 1'b1; ri = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_idle_%0d got %b want 0", k, valid_o); end
    end
    oh = 16'h0001; vi = 1'b1;
    step();
    vi = 1'b0;
    n_cmp++; if ({valid_o, bin_o, err_o} !== {1'b1, 4'd0, 1'b0}) begin n_fail++; $display("FAIL mid_restart got v=%b b=%0d e=%b want 1/0/0", valid_o, bin_o, err_o); end
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_malformed();
    test_backpressure();
    test_random();
    test_saturation();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
